// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// ALU operations and datapath mux codes.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_IF     = 3'd0,
        ST_ID     = 3'd1,
        ST_EX     = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SEL_IMM   = 2'd1;
    localparam logic [1:0] PC_SEL_JALR  = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_IMM  = 2'd3;

    // Access size (funct3[1:0]) to byte lanes, before the address-offset shift.
    function automatic logic [3:0] byte_en(input logic [1:0] size);
        case (size)
            2'b00:   byte_en = 4'b0001;
            2'b01:   byte_en = 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic opcode_legal(input logic [6:0] opc, input logic [2:0] funct3);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_OP_IMM, OPC_OP:  opcode_legal = 1'b1;
            OPC_LOAD, OPC_STORE:             opcode_legal = (funct3[1:0] != 2'b11);
            default:                         opcode_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_alu_decode.sv
// Combinational ALU control: opcode/funct3/funct7[5] to ALU operation and
// operand-source selects.
module rv_alu_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_b5,
    output logic [3:0] o_alu_op,
    output logic       o_src_a,
    output logic       o_src_b
);

    function automatic alu_op_e funct3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  funct3_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  funct3_op = ALU_SLL;
            3'b010:  funct3_op = ALU_SLT;
            3'b011:  funct3_op = ALU_SLTU;
            3'b100:  funct3_op = ALU_XOR;
            3'b101:  funct3_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  funct3_op = ALU_OR;
            default: funct3_op = ALU_AND;
        endcase
    endfunction

    always_comb begin
        o_alu_op = ALU_ADD;
        o_src_a  = 1'b0;
        o_src_b  = 1'b0;
        case (i_opcode)
            OPC_AUIPC, OPC_JAL: begin
                o_src_a = 1'b1;
                o_src_b = 1'b1;
            end
            OPC_LUI, OPC_JALR, OPC_LOAD, OPC_STORE: begin
                o_src_b = 1'b1;
            end
            OPC_BRANCH: begin
                o_alu_op = ALU_SUB;
            end
            OPC_OP_IMM: begin
                // Bit 30 of an I-immediate is only an opcode modifier for SRAI.
                o_src_b  = 1'b1;
                o_alu_op = funct3_op(i_funct3, (i_funct3 == 3'b101) && i_funct7_b5);
            end
            OPC_OP: begin
                o_alu_op = funct3_op(i_funct3, i_funct7_b5);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/MEM/WB with handshake
// timeouts, halt-marker detection, illegal-opcode trap and retire counter.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int          MAX_WAIT  = 16,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] HALT_PREV = 32'h00c00093,
    parameter logic [31:0] HALT_CUR  = 32'h00008067
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      INSTR,
    input  logic             I_MEM_RDY,
    input  logic             D_MEM_RDY,
    input  logic             BR_TAKEN,
    output logic             I_MEM_REQ,
    output logic             D_MEM_REQ,
    output logic             D_MEM_WEN,
    output logic [3:0]       D_MEM_BE,
    output logic             IR_WE,
    output logic             PC_WE,
    output logic [1:0]       PC_SEL,
    output logic             RF_WE,
    output logic [1:0]       WB_SEL,
    output logic             ALU_SRC_A,
    output logic             ALU_SRC_B,
    output logic [3:0]       ALU_OP,
    output logic [2:0]       STATE,
    output logic             HALT,
    output logic             ERR,
    output logic [CNT_W-1:0] RETIRED
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e           r_state;
    state_e           w_next;
    logic [7:0]       r_wait;
    logic [CNT_W-1:0] r_retired;
    logic [31:0]      r_prev_instr;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_is_store;
    logic [3:0] w_alu_op;
    logic       w_src_a;
    logic       w_src_b;
    logic       w_wait_last;

    assign w_opcode    = INSTR[6:0];
    assign w_funct3    = INSTR[14:12];
    assign w_is_store  = (w_opcode == OPC_STORE);
    assign w_wait_last = (r_wait == WAIT_LAST);

    rv_alu_decode u_alu_decode (
        .i_opcode    (w_opcode),
        .i_funct3    (w_funct3),
        .i_funct7_b5 (INSTR[30]),
        .o_alu_op    (w_alu_op),
        .o_src_a     (w_src_a),
        .o_src_b     (w_src_b)
    );

    assign STATE   = r_state;
    assign HALT    = (r_state == ST_HALTED);
    assign ERR     = (r_state == ST_ERROR);
    assign RETIRED = r_retired;

    always_comb begin
        w_next    = r_state;
        I_MEM_REQ = 1'b0;
        D_MEM_REQ = 1'b0;
        D_MEM_WEN = 1'b0;
        D_MEM_BE  = 4'b0000;
        IR_WE     = 1'b0;
        PC_WE     = 1'b0;
        PC_SEL    = PC_SEL_PLUS4;
        RF_WE     = 1'b0;
        WB_SEL    = WB_SEL_ALU;
        ALU_SRC_A = 1'b0;
        ALU_SRC_B = 1'b0;
        ALU_OP    = ALU_ADD;
        // Reset masks every strobe, even while the state register still holds its old value.
        if (!RST) begin
            case (r_state)
                ST_IF: begin
                    I_MEM_REQ = 1'b1;
                    if (I_MEM_RDY) begin
                        IR_WE  = 1'b1;
                        w_next = ST_ID;
                    end else if (w_wait_last) begin
                        w_next = ST_ERROR;
                    end
                end
                ST_ID: begin
                    if (!opcode_legal(w_opcode, w_funct3))
                        w_next = ST_ERROR;
                    else if (r_prev_instr == HALT_PREV && INSTR == HALT_CUR)
                        w_next = ST_HALTED;
                    else
                        w_next = ST_EX;
                end
                ST_EX: begin
                    ALU_SRC_A = w_src_a;
                    ALU_SRC_B = w_src_b;
                    ALU_OP    = w_alu_op;
                    if (w_opcode == OPC_BRANCH) begin
                        PC_WE  = 1'b1;
                        PC_SEL = BR_TAKEN ? PC_SEL_IMM : PC_SEL_PLUS4;
                        w_next = ST_IF;
                    end else if (w_opcode == OPC_LOAD || w_is_store) begin
                        w_next = ST_MEM;
                    end else begin
                        w_next = ST_WB;
                    end
                end
                ST_MEM: begin
                    D_MEM_REQ = 1'b1;
                    D_MEM_WEN = w_is_store;
                    D_MEM_BE  = byte_en(w_funct3[1:0]);
                    if (D_MEM_RDY) begin
                        if (w_is_store) begin
                            PC_WE  = 1'b1;
                            w_next = ST_IF;
                        end else begin
                            w_next = ST_WB;
                        end
                    end else if (w_wait_last) begin
                        w_next = ST_ERROR;
                    end
                end
                ST_WB: begin
                    RF_WE  = 1'b1;
                    PC_WE  = 1'b1;
                    w_next = ST_IF;
                    case (w_opcode)
                        OPC_LUI:           WB_SEL = WB_SEL_IMM;
                        OPC_JAL, OPC_JALR: WB_SEL = WB_SEL_PC4;
                        OPC_LOAD:          WB_SEL = WB_SEL_LOAD;
                        default:           WB_SEL = WB_SEL_ALU;
                    endcase
                    if (w_opcode == OPC_JAL)
                        PC_SEL = PC_SEL_IMM;
                    else if (w_opcode == OPC_JALR)
                        PC_SEL = PC_SEL_JALR;
                end
                ST_HALTED: ;
                ST_ERROR:  ;
                default:   w_next = ST_ERROR;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IF;
            r_wait       <= 8'd0;
            r_retired    <= '0;
            r_prev_instr <= 32'd0;
        end else begin
            r_state <= w_next;
            // Counts unanswered request cycles; any other cycle clears it, so each IF/MEM visit starts at 0.
            if ((I_MEM_REQ && !I_MEM_RDY) || (D_MEM_REQ && !D_MEM_RDY))
                r_wait <= r_wait + 8'd1;
            else
                r_wait <= 8'd0;
            if (PC_WE)
                r_retired <= r_retired + CNT_W'(1);
            if (r_state == ST_ID && w_next == ST_EX)
                r_prev_instr <= INSTR;
        end
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: a vector table of single instructions
// plus hand-written halt, timeout, illegal-opcode and reset sequences.
module tb_rv_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] INSTR = 32'd0;
    logic        I_MEM_RDY = 1'b0;
    logic        D_MEM_RDY = 1'b0;
    logic        BR_TAKEN = 1'b0;
    logic        I_MEM_REQ, D_MEM_REQ, D_MEM_WEN, IR_WE, PC_WE, RF_WE;
    logic        ALU_SRC_A, ALU_SRC_B, HALT, ERR;
    logic [3:0]  D_MEM_BE, ALU_OP;
    logic [1:0]  PC_SEL, WB_SEL;
    logic [2:0]  STATE;
    logic [31:0] RETIRED;

    rv_multicycle_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .INSTR     (INSTR),
        .I_MEM_RDY (I_MEM_RDY),
        .D_MEM_RDY (D_MEM_RDY),
        .BR_TAKEN  (BR_TAKEN),
        .I_MEM_REQ (I_MEM_REQ),
        .D_MEM_REQ (D_MEM_REQ),
        .D_MEM_WEN (D_MEM_WEN),
        .D_MEM_BE  (D_MEM_BE),
        .IR_WE     (IR_WE),
        .PC_WE     (PC_WE),
        .PC_SEL    (PC_SEL),
        .RF_WE     (RF_WE),
        .WB_SEL    (WB_SEL),
        .ALU_SRC_A (ALU_SRC_A),
        .ALU_SRC_B (ALU_SRC_B),
        .ALU_OP    (ALU_OP),
        .STATE     (STATE),
        .HALT      (HALT),
        .ERR       (ERR),
        .RETIRED   (RETIRED)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic        br;
        int          dd;
        int          cyc;
        int          rf;
        int          dreq;
        logic [1:0]  wb;
        logic [1:0]  pc;
        logic [3:0]  be;
        logic        wen;
        logic [3:0]  alu;
        logic        a;
        logic        b;
    } vec_t;

    typedef struct {
        int          cycles;
        int          rf_n;
        int          pcwe_n;
        int          dreq_n;
        int          ireq_n;
        logic [1:0]  wb;
        logic [1:0]  pc;
        logic [3:0]  be;
        logic        wen;
        logic [3:0]  alu;
        logic        a;
        logic        b;
        logic [2:0]  first_state;
    } meas_t;

    int    checks  = 0;
    int    errors  = 0;
    int    exp_ret = 0;
    vec_t  vecs[19];
    meas_t m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic irdy, input logic drdy);
        @(negedge CLK);
        I_MEM_RDY = irdy;
        D_MEM_RDY = drdy;
        #1;
    endtask

    // Reset cycle with both RDYs high: every strobe must still read 0.
    task automatic do_reset(input string tag);
        @(negedge CLK);
        RST = 1'b1;
        I_MEM_RDY = 1'b1;
        D_MEM_RDY = 1'b1;
        #1;
        chk({tag, " strobes in reset"},
            32'({I_MEM_REQ, D_MEM_REQ, D_MEM_WEN, IR_WE, PC_WE, RF_WE}), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        I_MEM_RDY = 1'b0;
        D_MEM_RDY = 1'b0;
        #1;
        exp_ret = 0;
    endtask

    // Runs one instruction from IF until the PC_WE cycle; RDY is granted after i_dly/d_dly unanswered REQ cycles.
    task automatic run_instr(input logic [31:0] instr, input logic br, input int i_dly,
                             input int d_dly, output meas_t r);
        r = '{default: 0};
        INSTR = instr;
        BR_TAKEN = br;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            I_MEM_RDY = (r.ireq_n >= i_dly);
            D_MEM_RDY = (r.dreq_n >= d_dly);
            #1;
            if (c == 0) r.first_state = STATE;
            if (I_MEM_REQ) r.ireq_n++;
            if (D_MEM_REQ) begin
                r.dreq_n++;
                r.be  = D_MEM_BE;
                r.wen = D_MEM_WEN;
            end
            if (RF_WE) begin
                r.rf_n++;
                r.wb = WB_SEL;
            end
            if (STATE == 3'd2) begin
                r.alu = ALU_OP;
                r.a   = ALU_SRC_A;
                r.b   = ALU_SRC_B;
            end
            r.cycles++;
            if (PC_WE) begin
                r.pcwe_n++;
                r.pc = PC_SEL;
                break;
            end
        end
        @(posedge CLK);
        #1;
        I_MEM_RDY = 1'b0;
        D_MEM_RDY = 1'b0;
    endtask

    // Zero-wait memory until the FSM parks in HALTED or ERROR; returns the cycle index it was first seen.
    task automatic run_to_stop(input logic [31:0] instr, output int n, output logic [2:0] st);
        INSTR = instr;
        n = -1;
        st = 3'd7;
        for (int c = 0; c < 40; c++) begin
            cyc(1'b1, 1'b1);
            if (STATE == 3'd5 || STATE == 3'd6) begin
                n = c;
                st = STATE;
                break;
            end
        end
    endtask

    initial begin
        int          n;
        int          req_n;
        logic        any_req;
        logic [2:0]  st;

        //              instr         br    dd cyc rf dreq wb    pc    be     wen   alu    a     b
        vecs[0]  = '{32'h002081b3, 1'b0, 0, 4, 1, 0, 2'd0, 2'd0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0}; // add
        vecs[1]  = '{32'h402081b3, 1'b0, 0, 4, 1, 0, 2'd0, 2'd0, 4'h0, 1'b0, 4'd1, 1'b0, 1'b0}; // sub
        vecs[2]  = '{32'h0020b1b3, 1'b0, 0, 4, 1, 0, 2'd0, 2'd0, 4'h0, 1'b0, 4'd4, 1'b0, 1'b0}; // sltu
        vecs[3]  = '{32'h4020d1b3, 1'b0, 0, 4, 1, 0, 2'd0, 2'd0, 4'h0, 1'b0, 4'd7, 1'b0, 1'b0}; // sra
        vecs[4]  = '{32'h0020d1b3, 1'b0, 0, 4, 1, 0, 2'd0, 2'd0, 4'h0, 1'b0, 4'd6, 1'b0, 1'b0}; // srl
        vecs[5]  = '{32'h4030d093, 1'b0, 0, 4, 1, 0, 2'd0, 2'd0, 4'h0, 1'b0, 4'd7, 1'b0, 1'b1}; // srai
        vecs[6]  = '{32'h40000093, 1'b0, 0, 4, 1, 0, 2'd0, 2'd0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b1}; // addi 1024
        vecs[7]  = '{32'h0000c093, 1'b0, 0, 4, 1, 0, 2'd0, 2'd0, 4'h0, 1'b0, 4'd5, 1'b0, 1'b1}; // xori
        vecs[8]  = '{32'h123450b7, 1'b0, 0, 4, 1, 0, 2'd3, 2'd0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b1}; // lui
        vecs[9]  = '{32'h00001097, 1'b0, 0, 4, 1, 0, 2'd0, 2'd0, 4'h0, 1'b0, 4'd0, 1'b1, 1'b1}; // auipc
        vecs[10] = '{32'h008000ef, 1'b0, 0, 4, 1, 0, 2'd2, 2'd1, 4'h0, 1'b0, 4'd0, 1'b1, 1'b1}; // jal
        vecs[11] = '{32'h00008067, 1'b0, 0, 4, 1, 0, 2'd2, 2'd2, 4'h0, 1'b0, 4'd0, 1'b0, 1'b1}; // jalr
        vecs[12] = '{32'h0000a103, 1'b0, 3, 8, 1, 4, 2'd1, 2'd0, 4'hf, 1'b0, 4'd0, 1'b0, 1'b1}; // lw, 3 waits
        vecs[13] = '{32'h0020a023, 1'b0, 0, 4, 0, 1, 2'd0, 2'd0, 4'hf, 1'b1, 4'd0, 1'b0, 1'b1}; // sw
        vecs[14] = '{32'h00209023, 1'b0, 2, 6, 0, 3, 2'd0, 2'd0, 4'h3, 1'b1, 4'd0, 1'b0, 1'b1}; // sh, 2 waits
        vecs[15] = '{32'h00008103, 1'b0, 0, 5, 1, 1, 2'd1, 2'd0, 4'h1, 1'b0, 4'd0, 1'b0, 1'b1}; // lb
        vecs[16] = '{32'h00208463, 1'b1, 0, 3, 0, 0, 2'd0, 2'd1, 4'h0, 1'b0, 4'd1, 1'b0, 1'b0}; // beq taken
        vecs[17] = '{32'h00208463, 1'b0, 0, 3, 0, 0, 2'd0, 2'd0, 4'h0, 1'b0, 4'd1, 1'b0, 1'b0}; // beq not taken
        vecs[18] = '{32'h0020f1b3, 1'b0, 0, 4, 1, 0, 2'd0, 2'd0, 4'h0, 1'b0, 4'd9, 1'b0, 1'b0}; // and

        do_reset("init");
        chk("init STATE", 32'(STATE), 32'd0);
        chk("init RETIRED", RETIRED, 32'd0);
        chk("init HALT/ERR", 32'({HALT, ERR}), 32'd0);

        for (int i = 0; i < 19; i++) begin
            run_instr(vecs[i].instr, vecs[i].br, 0, vecs[i].dd, m);
            exp_ret++;
            chk($sformatf("v%0d first state", i), 32'(m.first_state), 32'd0);
            chk($sformatf("v%0d cycles", i), m.cycles, vecs[i].cyc);
            chk($sformatf("v%0d pc_we count", i), m.pcwe_n, 1);
            chk($sformatf("v%0d pc_sel", i), 32'(m.pc), 32'(vecs[i].pc));
            chk($sformatf("v%0d rf_we count", i), m.rf_n, vecs[i].rf);
            chk($sformatf("v%0d d_req cycles", i), m.dreq_n, vecs[i].dreq);
            chk($sformatf("v%0d alu {op,a,b}", i), 32'({m.alu, m.a, m.b}),
                32'({vecs[i].alu, vecs[i].a, vecs[i].b}));
            if (vecs[i].rf != 0)
                chk($sformatf("v%0d wb_sel", i), 32'(m.wb), 32'(vecs[i].wb));
            if (vecs[i].dreq != 0)
                chk($sformatf("v%0d {be,wen}", i), 32'({m.be, m.wen}), 32'({vecs[i].be, vecs[i].wen}));
            chk($sformatf("v%0d retired", i), RETIRED, exp_ret);
            $display("vec %0d instr %08h cycles %0d pc_sel %0d retired %0d",
                     i, vecs[i].instr, m.cycles, m.pc, RETIRED);
        end

        // Halt marker pair: only the first instruction retires.
        run_instr(32'h00c00093, 1'b0, 0, 0, m);
        exp_ret++;
        chk("halt prev retired", RETIRED, exp_ret);
        run_to_stop(32'h00008067, n, st);
        chk("halt stop cycle", n, 2);
        chk("halt state", 32'(st), 32'd5);
        chk("halt flags {HALT,ERR}", 32'({HALT, ERR}), 32'h2);
        any_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc(1'b1, 1'b1);
            any_req = any_req | I_MEM_REQ | D_MEM_REQ | PC_WE;
        end
        chk("halt no strobes", 32'(any_req), 32'd0);
        chk("halt retired held", RETIRED, exp_ret);
        $display("halt sequence: state %0d retired %0d", STATE, RETIRED);
        do_reset("halt");
        chk("halt cleared", 32'(HALT), 32'd0);
        chk("halt reset retired", RETIRED, 32'd0);

        // Instruction fetch never answered: error after MAX_WAIT request cycles.
        INSTR = 32'h002081b3;
        req_n = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(1'b0, 1'b0);
            if (I_MEM_REQ) req_n++;
            if (STATE == 3'd6) break;
        end
        chk("ifetch timeout req cycles", req_n, 16);
        chk("ifetch timeout ERR", 32'({ERR, STATE}), 32'({1'b1, 3'd6}));
        $display("ifetch timeout: req cycles %0d err %0d", req_n, ERR);
        do_reset("ifetch timeout");
        chk("ifetch timeout ERR cleared", 32'(ERR), 32'd0);

        // I_MEM_RDY on the last allowed request cycle still succeeds.
        run_instr(32'h002081b3, 1'b0, 15, 0, m);
        exp_ret++;
        chk("ifetch boundary cycles", m.cycles, 19);
        chk("ifetch boundary req cycles", m.ireq_n, 16);
        chk("ifetch boundary no ERR", 32'(ERR), 32'd0);
        chk("ifetch boundary retired", RETIRED, exp_ret);
        $display("ifetch boundary: cycles %0d retired %0d", m.cycles, RETIRED);

        // Same boundary on the data side.
        run_instr(32'h0000a103, 1'b0, 0, 15, m);
        exp_ret++;
        chk("dmem boundary cycles", m.cycles, 20);
        chk("dmem boundary req cycles", m.dreq_n, 16);
        chk("dmem boundary wb_sel", 32'(m.wb), 32'd1);
        chk("dmem boundary retired", RETIRED, exp_ret);
        $display("dmem boundary: cycles %0d retired %0d", m.cycles, RETIRED);

        // Data access never answered.
        INSTR = 32'h0000a103;
        req_n = 0;
        for (int c = 0; c < 60; c++) begin
            cyc(1'b1, 1'b0);
            if (D_MEM_REQ) req_n++;
            if (STATE == 3'd6) break;
        end
        chk("dmem timeout req cycles", req_n, 16);
        chk("dmem timeout ERR", 32'(ERR), 32'd1);
        chk("dmem timeout retired", RETIRED, exp_ret);
        $display("dmem timeout: req cycles %0d err %0d", req_n, ERR);
        do_reset("dmem timeout");

        // Illegal opcode, then a LOAD with funct3[1:0]=11.
        run_to_stop(32'h0000007f, n, st);
        chk("illegal opc stop cycle", n, 2);
        chk("illegal opc state", 32'({ERR, st}), 32'({1'b1, 3'd6}));
        $display("illegal opcode: state %0d err %0d", st, ERR);
        do_reset("illegal opc");
        chk("illegal opc ERR cleared", 32'(ERR), 32'd0);
        run_to_stop(32'h0000b103, n, st);
        chk("illegal size state", 32'({ERR, st}), 32'({1'b1, 3'd6}));
        $display("illegal load size: state %0d err %0d", st, ERR);
        do_reset("illegal size");

        // Reset in the middle of a data wait, then a byte store.
        run_instr(32'h002081b3, 1'b0, 0, 0, m);
        chk("pre-abort retired", RETIRED, 32'd1);
        INSTR = 32'h0000a103;
        for (int c = 0; c < 6; c++) cyc(1'b1, 1'b0);
        chk("abort in MEM", 32'({STATE, D_MEM_REQ}), 32'({3'd3, 1'b1}));
        do_reset("abort");
        chk("abort state", 32'(STATE), 32'd0);
        chk("abort data strobes", 32'({D_MEM_REQ, D_MEM_WEN, PC_WE, RF_WE, IR_WE}), 32'd0);
        chk("abort retired", RETIRED, 32'd0);
        run_instr(32'h00208023, 1'b0, 0, 0, m);
        exp_ret++;
        chk("sb {be,wen}", 32'({m.be, m.wen}), 32'({4'b0001, 1'b1}));
        chk("sb cycles", m.cycles, 4);
        chk("sb retired", RETIRED, exp_ret);
        $display("sb after abort: be %04b wen %0d retired %0d", m.be, m.wen, RETIRED);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
